// File: rtl/c3lib_ckbuf_gate_pkg.sv
// Shared types for the c3lib clock-buffer enable controller.
package c3lib_ckbuf_gate_pkg;

  typedef enum logic [1:0] {
    OFF       = 2'd0,
    WAKE      = 2'd1,
    ON        = 2'd2,
    IDLE_WAIT = 2'd3
  } gate_state_e;

  localparam int STATS_W = 16;

endpackage

// File: rtl/c3lib_ckbuf_gate_cnt.sv
// Loadable down-counter that sticks at zero; shared by the wake and idle intervals.
module c3lib_ckbuf_gate_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  cnt <= '0;
    else if (load)               cnt <= load_val;
    else if (dec && cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/c3lib_ckbuf_gate_ctrl.sv
// Clock-buffer enable sequencer: wake interval, per-requester ack, idle hysteresis.
// Optional wake statistics counter under C3LIB_CKBUF_GATE_CTRL_STATS_EN.
module c3lib_ckbuf_gate_ctrl
  import c3lib_ckbuf_gate_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int WAKE_CYC = 4,
  parameter int IDLE_CYC = 16,
  parameter int CNT_W    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               force_on,
  output logic [NUM_REQ-1:0] ack,
  output logic               ck_en,
  output logic               busy
`ifdef C3LIB_CKBUF_GATE_CTRL_STATS_EN
  ,
  output logic [STATS_W-1:0] wake_cnt
`endif
);

  localparam logic [CNT_W-1:0] WAKE_LD = CNT_W'(WAKE_CYC - 1);
  localparam logic [CNT_W-1:0] IDLE_LD = CNT_W'(IDLE_CYC - 1);

  gate_state_e      st, nxt;
  logic             any;
  logic             ld, dec, zero;
  logic [CNT_W-1:0] ld_val;

  assign any = (|req) | force_on;

  c3lib_ckbuf_gate_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ld),
    .load_val (ld_val),
    .dec      (dec),
    .zero     (zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= OFF;
    else        st <= nxt;
  end

  always_comb begin
    nxt    = st;
    ld     = 1'b0;
    ld_val = '0;
    dec    = 1'b0;
    case (st)
      OFF: if (any) begin
        nxt    = WAKE;
        ld     = 1'b1;
        ld_val = WAKE_LD;
      end
      // Wake always runs to completion so the buffer is never cut mid-settle.
      WAKE: if (zero) nxt = ON;
            else      dec = 1'b1;
      ON: if (!any) begin
        nxt    = IDLE_WAIT;
        ld     = 1'b1;
        ld_val = IDLE_LD;
      end
      IDLE_WAIT: if (any)       nxt = ON;
                 else if (zero) nxt = OFF;
                 else           dec = 1'b1;
      default: nxt = OFF;
    endcase
  end

  // Outputs are registered from next-state so they move on the same edge as st.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack   <= '0;
      ck_en <= 1'b0;
      busy  <= 1'b0;
    end else begin
      ack   <= req & {NUM_REQ{nxt == ON}};
      ck_en <= (nxt != OFF);
      busy  <= (nxt != OFF);
    end
  end

`ifdef C3LIB_CKBUF_GATE_CTRL_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      wake_cnt <= '0;
    else if (st == OFF && nxt == WAKE && wake_cnt != {STATS_W{1'b1}})
      wake_cnt <= wake_cnt + 1'b1;
  end
`endif

endmodule
